// File: rtl/multiplexing_sequencer_pkg.sv
// rtl/multiplexing_sequencer_pkg.sv - shared types and width helpers for the multiplexing sequencer
package multiplexing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ACTIVE
    } mux_state_t;

    typedef enum logic {
        MODE_LINEAR,
        MODE_INTERLEAVED
    } mux_mode_t;

    // Index width that never collapses to zero bits for single-entry ranges
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int row_cycles, input int dead_cycles);
        int mx;
        mx = (row_cycles > dead_cycles) ? row_cycles : dead_cycles;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/multiplexing_sequencer_if.sv
// rtl/multiplexing_sequencer_if.sv - control/status bundle between driver logic and the sequencer
interface multiplexing_sequencer_if import multiplexing_pkg::*; #(
    parameter int NB_MUX_ROWS       = 4,
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_LED_ROWS       = 32
);
    logic                                   enable;
    logic                                   mode;
    logic [idx_width(NB_LEDS_PER_GROUP)-1:0] led;
    logic [idx_width(NB_LED_ROWS)-1:0]       led_row;
    logic [NB_MUX_ROWS-1:0]                  row_en;
    logic [idx_width(NB_MUX_ROWS)-1:0]       load_row;
    logic                                   row_start;
    logic                                   frame_start;
    logic                                   latch;

    modport master (
        output enable, mode, led,
        input  led_row, row_en, load_row, row_start, frame_start, latch
    );

    modport slave (
        input  enable, mode, led,
        output led_row, row_en, load_row, row_start, frame_start, latch
    );
endinterface

// File: rtl/multiplexing_sequencer_map.sv
// rtl/multiplexing_sequencer_map.sv - combinational driver-output to physical LED row mapping
module multiplexing_map import multiplexing_pkg::*; #(
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_LED_ROWS       = 32,
    parameter int LOAD_ROW_W        = 2,
    localparam int LED_W            = idx_width(NB_LEDS_PER_GROUP),
    localparam int LROW_W           = idx_width(NB_LED_ROWS)
) (
    input  logic [LOAD_ROW_W-1:0] load_row_i,
    input  logic [LED_W-1:0]      led_i,
    input  mux_mode_t             mode_i,
    output logic [LROW_W-1:0]     led_row_o
);
    localparam int R = (NB_LED_ROWS / NB_LEDS_PER_GROUP > 0) ? NB_LED_ROWS / NB_LEDS_PER_GROUP : 1;
    localparam logic [LROW_W-1:0] GROUP_MUL = LROW_W'(NB_LEDS_PER_GROUP);
    localparam logic [LROW_W-1:0] R_MUL     = LROW_W'(R);

    logic [LROW_W-1:0] m;
    logic [LROW_W-1:0] led_w;

    always_comb begin
        m     = LROW_W'(int'(load_row_i) % R);
        led_w = LROW_W'(led_i);
        if (mode_i == MODE_INTERLEAVED) begin
            led_row_o = led_w * R_MUL + m;
        end else begin
            led_row_o = m * GROUP_MUL + led_w;
        end
    end
endmodule

// File: rtl/multiplexing_sequencer.sv
// rtl/multiplexing_sequencer.sv - row-enable sequencer with dead-time blanking and row/frame strobes
module multiplexing_sequencer import multiplexing_pkg::*; #(
    parameter int NB_MUX_ROWS       = 4,
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_LED_ROWS       = 32,
    parameter int ROW_CYCLES        = 512,
    parameter int DEAD_CYCLES       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    multiplexing_sequencer_if.slave   bus
);
    localparam int R      = NB_LED_ROWS / NB_LEDS_PER_GROUP;
    localparam int R_SAFE = (R > 0) ? R : 1;
    localparam int ROW_W  = idx_width(NB_MUX_ROWS);
    localparam int CNT_W  = cnt_width(ROW_CYCLES, DEAD_CYCLES);

    localparam logic [ROW_W-1:0]       LAST_ROW  = ROW_W'(NB_MUX_ROWS - 1);
    localparam logic [CNT_W-1:0]       ROW_LAST  = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0]       DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [NB_MUX_ROWS-1:0] ROW_ONE   = NB_MUX_ROWS'(1);

    if (R < 1 || NB_LED_ROWS % NB_LEDS_PER_GROUP != 0) begin : g_bad_led_rows
        $error("NB_LED_ROWS must be a non-zero multiple of NB_LEDS_PER_GROUP");
    end
    if (NB_MUX_ROWS % R_SAFE != 0) begin : g_bad_mux_rows
        $error("NB_MUX_ROWS must be a multiple of NB_LED_ROWS/NB_LEDS_PER_GROUP");
    end
    if (ROW_CYCLES < 1 || DEAD_CYCLES < 1) begin : g_bad_cycles
        $error("ROW_CYCLES and DEAD_CYCLES must be at least 1");
    end

    mux_state_t             state_q, state_d;
    logic [ROW_W-1:0]       cur_row_q, cur_row_d, next_row;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    mux_mode_t              mode_q, mode_d;
    logic [NB_MUX_ROWS-1:0] row_en_q, row_en_d;
    logic [ROW_W-1:0]       load_row_q, load_row_d;
    logic                   row_start_q, row_start_d;
    logic                   frame_start_q, frame_start_d;
    logic                   latch_q, latch_d;
    logic                   entering_blank;

    always_comb begin
        state_d        = state_q;
        cur_row_d      = cur_row_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        entering_blank = 1'b0;
        next_row       = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + 1'b1;

        case (state_q)
            IDLE: begin
                mode_d = mux_mode_t'(bus.mode);
                cnt_d  = '0;
                if (bus.enable) begin
                    state_d   = BLANK;
                    cur_row_d = '0;
                end
            end
            BLANK: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                // A row always runs to completion; enable is only consulted at its end
                if (cnt_q == ROW_LAST) begin
                    cnt_d = '0;
                    if (bus.enable) begin
                        state_d   = BLANK;
                        cur_row_d = next_row;
                    end else begin
                        state_d   = IDLE;
                        cur_row_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        entering_blank = (state_d == BLANK) && (state_q != BLANK);
        // Mode is frame-coherent: only re-sampled as row 0 begins blanking
        if (entering_blank && cur_row_d == '0) begin
            mode_d = mux_mode_t'(bus.mode);
        end

        latch_d       = entering_blank;
        frame_start_d = entering_blank && (cur_row_d == '0);
        row_start_d   = (state_d == ACTIVE) && (state_q != ACTIVE);
        row_en_d      = (state_d == ACTIVE) ? (ROW_ONE << cur_row_d) : '0;
        if (state_d == IDLE) begin
            load_row_d = '0;
        end else begin
            load_row_d = (cur_row_d == LAST_ROW) ? '0 : cur_row_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_row_q     <= '0;
            cnt_q         <= '0;
            mode_q        <= MODE_LINEAR;
            row_en_q      <= '0;
            load_row_q    <= '0;
            row_start_q   <= 1'b0;
            frame_start_q <= 1'b0;
            latch_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_row_q     <= cur_row_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            row_en_q      <= row_en_d;
            load_row_q    <= load_row_d;
            row_start_q   <= row_start_d;
            frame_start_q <= frame_start_d;
            latch_q       <= latch_d;
        end
    end

    assign bus.row_en      = row_en_q;
    assign bus.load_row    = load_row_q;
    assign bus.row_start   = row_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.latch       = latch_q;

    multiplexing_map #(
        .NB_LEDS_PER_GROUP (NB_LEDS_PER_GROUP),
        .NB_LED_ROWS       (NB_LED_ROWS),
        .LOAD_ROW_W        (ROW_W)
    ) u_map (
        .load_row_i (load_row_q),
        .led_i      (bus.led),
        .mode_i     (mode_q),
        .led_row_o  (bus.led_row)
    );
endmodule
